// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: combinational hits, 4-word line
// fills from a line-oriented memory, saturating hit/miss counters.
module icache_direct_mapped #(
  parameter int WORD_SIZE      = 16,
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_BITS     = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_read,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  output logic [WORD_SIZE-1:0]   cpu_data,
  output logic                   cpu_ready,
  input  logic                   flush,
  output logic                   mem_read,
  output logic [WORD_SIZE-1:0]   mem_addr,
  input  logic [4*WORD_SIZE-1:0] mem_data,
  input  logic                   mem_valid,
  output logic [WORD_SIZE-1:0]   num_hit,
  output logic [WORD_SIZE-1:0]   num_miss
);
  localparam int TAG_BITS  = WORD_SIZE - INDEX_BITS - 2;
  localparam int LINE_BITS = WORDS_PER_LINE * WORD_SIZE;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_BITS-1:0]    tags  [NUM_LINES];
  logic [LINE_BITS-1:0]   lines [NUM_LINES];

  logic [1:0]             offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [TAG_BITS-1:0]    fill_tag;
  logic                   lookup;
  logic                   hit;
  logic                   miss;
  logic                   fill_done;

  assign offset = cpu_addr[1:0];
  assign index  = cpu_addr[INDEX_BITS+1:2];
  assign tag    = cpu_addr[WORD_SIZE-1:INDEX_BITS+2];

  // The latched line address doubles as the fill index/tag record.
  assign fill_index = mem_addr[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr[WORD_SIZE-1:INDEX_BITS+2];

  assign lookup    = (state == IDLE) && cpu_read && !flush;
  assign hit       = lookup && valid[index] && (tags[index] == tag);
  assign miss      = lookup && !hit;
  assign fill_done = (state == FILL) && mem_valid;

  assign cpu_ready = hit;
  assign cpu_data  = hit ? lines[index][int'(offset)*WORD_SIZE +: WORD_SIZE] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      valid    <= '0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      num_hit  <= '0;
      num_miss <= '0;
    end else begin
      if (hit && num_hit != '1)
        num_hit <= num_hit + WORD_SIZE'(1);
      if (miss && num_miss != '1)
        num_miss <= num_miss + WORD_SIZE'(1);
      // Flush clears first so a coincident fill still lands valid.
      if (flush)
        valid <= '0;
      case (state)
        IDLE: begin
          if (miss) begin
            state    <= FILL;
            mem_read <= 1'b1;
            mem_addr <= {tag, index, 2'b00};
          end
        end
        FILL: begin
          if (mem_valid) begin
            state             <= IDLE;
            mem_read          <= 1'b0;
            valid[fill_index] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      lines[fill_index] <= mem_data;
      tags[fill_index]  <= fill_tag;
    end
  end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
Direct-mapped, read-only instruction cache between the CPU fetch port (readM1/address1/data1 side) and a slower line-oriented instruction memory. Hits return the fetch word combinationally in the same cycle. Misses stall the CPU while a 4-word line is fetched. Hit and miss counters are exported for the testbench to report alongside num_inst.

Parameters:
WORD_SIZE, 16, data and address width in bits
NUM_LINES, 8, number of cache lines; power of two
WORDS_PER_LINE, 4, fixed; 2 offset bits
INDEX_BITS, 3, log2(NUM_LINES)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
cpu_read  input  1  fetch request from the CPU
cpu_addr  input  WORD_SIZE  word address of the fetch
cpu_data  output  WORD_SIZE  fetched instruction; valid only when cpu_ready=1
cpu_ready  output  1  fetch satisfied this cycle; the CPU stalls fetch while cpu_read=1 and cpu_ready=0
flush  input  1  invalidate all lines
mem_read  output  1  line-fill request to memory
mem_addr  output  WORD_SIZE  line-aligned fill address, {tag,index,2'b00}
mem_data  input  4*WORD_SIZE  fill line; bits [15:0] hold offset 0 and bits [63:48] hold offset 3
mem_valid  input  1  mem_data valid this cycle; one-cycle pulse
num_hit  output  WORD_SIZE  count of hits; saturates at 16'hFFFF
num_miss  output  WORD_SIZE  count of misses; saturates at 16'hFFFF

Behaviour:
- Address split: offset = addr[1:0], index = addr[INDEX_BITS+1:2], tag = the remaining upper bits (11 bits at the defaults).
- Storage per line: valid bit, tag, and 4 data words.
- Reset (asynchronous, reset_n=0), taking effect immediately:
  - All valid bits 0, state IDLE.
  - mem_read=0, mem_addr=0, cpu_ready=0, cpu_data=0.
  - num_hit=0, num_miss=0.
- FSM states: IDLE and FILL.
- IDLE:
  - hit = cpu_read & valid[index] & (tag match).
  - cpu_ready = hit and cpu_data = the selected word, both combinational; 0-cycle latency.
  - On hit: num_hit increments at the edge.
  - If cpu_read=1 and the lookup misses: latch the tag and index, increment num_miss, go to FILL at the edge.
  - cpu_read=0: cpu_ready=0, no state change.
- FILL:
  - mem_read=1, mem_addr = the latched line address, held stable until mem_valid is seen. mem_read stays 1 in the mem_valid cycle.
  - cpu_ready=0 regardless of the CPU address.
  - When mem_valid=1: write the line, set valid and tag, go to IDLE at the edge. mem_read is 0 from the next cycle.
  - The next IDLE cycle re-looks up and hits if the address is unchanged.
  - Miss penalty with memory latency L cycles (mem_valid arrives L cycles after mem_read rises) = L+2 cycles: miss cycle + L fill cycles + hit cycle.
- CPU address change during FILL: the fill for the latched line still completes and installs; the lookup then uses the new address in IDLE.
- flush:
  - Clears all valid bits at the edge.
  - cpu_ready is forced 0 in any cycle with flush=1; no hit or miss is counted.
  - flush in the same cycle as mem_valid: the fill line is still written valid; the fill wins for its entry and all other entries are cleared.
- Conflict miss: two addresses with the same index and different tags evict each other. Each access after the first is a miss.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset during FILL: abandon the fill. mem_read drops asynchronously; a later mem_valid pulse in IDLE is ignored.
- mem_valid arriving while in IDLE is ignored.

Test Plan:
- Cold fetch: after reset, cpu_read=1, cpu_addr=16'h0000, memory with L=2 returning line {4'h3,4'h2,4'h1,4'h0 words} -> cpu_ready=0 for 3 cycles, mem_addr=16'h0000, then cpu_ready=1 with cpu_data=word0; num_miss=1, num_hit=1.
- Sequential fetch 0x0000..0x0007 with L=2 -> exactly 2 fills (mem_addr 0x0000, then 0x0004), num_miss=2, num_hit=8, every word correct.
- Conflict: alternate fetches of 0x0000 and 0x0020 (same index 0) 4 times -> 8 misses, 0 hits, mem_read asserted 8 times.
- Flush: warm line 0x0004, pulse flush for 1 cycle, fetch 0x0005 -> miss, refetch from mem_addr 0x0004; flush coincident with mem_valid -> the filled line hits afterwards.
- Reset mid-FILL: assert reset_n=0 two cycles into a fill -> mem_read=0 immediately, counters 0; a stray mem_valid after release is ignored; the next fetch of the same address misses.
- Saturation: force 65,536+ hits on one resident line -> num_hit holds at 16'hFFFF.
